// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and default constants for the unified instruction/data RAM
// arbiter (mem_arbiter) and its aging counter (arb_age_counter).
//   owner_t   : which port the read currently in flight belongs to
//   req_id_t  : which requester is granted in the current cycle
//   DEF_*     : default RAM word-address and data widths
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 31;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_LS = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_IF   = 2'd1,
        REQ_LS   = 2'd2
    } req_id_t;

endpackage

// File: rtl/arb_age_counter.sv
// -----------------------------------------------------------------------------
// arb_age_counter
// Saturating wait counter used to age a low-priority requester.
// Ports:
//   clk      in   system clock (rising edge)
//   s_reset  in   synchronous active-high reset, clears the count
//   inc_i    in   requester waited this cycle (count up, saturate at all-ones)
//   clr_i    in   requester served or idle (count back to 0); wins over inc_i
//   limit_o  out  count has reached LIMIT
// -----------------------------------------------------------------------------
module arb_age_counter #(
    parameter int WIDTH = 12,
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic s_reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic limit_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign limit_o = (count_q >= WIDTH'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port unified RAM between instruction fetch (IF, reads
// only) and the load/store unit (LS). One access is granted per cycle; LS has
// fixed priority unless IF has waited STARVE_LIMIT cycles. RAM read latency is
// one cycle and the owner FSM routes the returning word to the issuing port.
//
// Handshake: a requester holds req and its payload until it sees gnt in the
// same cycle; the access is then complete from its point of view. For reads,
// rvalid/rdata appear exactly one cycle after gnt. There is no back-pressure
// on the return path.
//
// Ports:
//   clk, s_reset                     clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt         IF request side
//   if_rvalid/if_rdata               IF read return
//   ls_req/ls_we/ls_addr/ls_wdata/ls_be -> ls_gnt   LS request side
//   ls_rvalid/ls_rdata               LS read return
//   ram_en/ram_we/ram_addr/ram_wdata/ram_be, ram_rdata   RAM interface
//   dbg_owner                        current owner FSM state
//   stat_if_grants/stat_ls_grants/stat_conflicts   only with MEM_ARB_STATS_EN
//
// Optional build macro: MEM_ARB_STATS_EN adds wrapping grant/conflict counters.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT  = 8,
    parameter int COUNTER_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    s_reset,

    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,

    input  logic                    ls_req,
    input  logic                    ls_we,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_be,
    output logic                    ls_gnt,
    output logic                    ls_rvalid,
    output logic [DATA_WIDTH-1:0]   ls_rdata,

    output logic                    ram_en,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [DATA_WIDTH/8-1:0] ram_be,
    input  logic [DATA_WIDTH-1:0]   ram_rdata,

    output owner_t                  dbg_owner
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [COUNTER_WIDTH-1:0] stat_if_grants,
    output logic [COUNTER_WIDTH-1:0] stat_ls_grants,
    output logic [COUNTER_WIDTH-1:0] stat_conflicts
`endif
);

    owner_t  owner_q;
    owner_t  owner_d;
    req_id_t grant_id;
    logic    if_aged;

    // IF aging: counts cycles IF is left waiting; cleared when served or idle.
    arb_age_counter #(
        .WIDTH (COUNTER_WIDTH),
        .LIMIT (STARVE_LIMIT)
    ) u_if_age (
        .clk     (clk),
        .s_reset (s_reset),
        .inc_i   (if_req && !if_gnt),
        .clr_i   (if_gnt || !if_req),
        .limit_o (if_aged)
    );

    // Grant decision. Nothing is granted while reset is asserted so no RAM
    // access or return can be started from a half-reset state.
    always_comb begin
        grant_id = REQ_NONE;
        if (!s_reset) begin
            if (ls_req && !(if_req && if_aged)) begin
                grant_id = REQ_LS;
            end else if (if_req) begin
                grant_id = REQ_IF;
            end
        end
    end

    assign if_gnt = (grant_id == REQ_IF);
    assign ls_gnt = (grant_id == REQ_LS);

    // RAM payload mux; IF is read-only so write controls stay low for it.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_be    = '0;
        case (grant_id)
            REQ_LS: begin
                ram_en    = 1'b1;
                ram_we    = ls_we;
                ram_addr  = ls_addr;
                ram_wdata = ls_wdata;
                ram_be    = ls_be;
            end
            REQ_IF: begin
                ram_en   = 1'b1;
                ram_addr = if_addr;
            end
            default: ;
        endcase
    end

    // Owner FSM: state register.
    always_ff @(posedge clk) begin
        if (s_reset) begin
            owner_q <= IDLE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Owner FSM: next state. Each state accepts a new grant, so the only
    // input is who is granted now; LS writes leave nothing in flight.
    always_comb begin
        owner_d = IDLE;
        case (grant_id)
            REQ_IF:  owner_d = RD_IF;
            REQ_LS:  owner_d = ls_we ? IDLE : RD_LS;
            default: owner_d = IDLE;
        endcase
    end

    // Owner FSM: outputs. Gated by reset so a read granted just before reset
    // never reports its data.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rvalid = 1'b0;
        ls_rdata  = '0;
        if (!s_reset) begin
            case (owner_q)
                RD_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = ram_rdata;
                end
                RD_LS: begin
                    ls_rvalid = 1'b1;
                    ls_rdata  = ram_rdata;
                end
                default: ;
            endcase
        end
    end

    assign dbg_owner = owner_q;

`ifdef MEM_ARB_STATS_EN
    logic [COUNTER_WIDTH-1:0] stat_if_q;
    logic [COUNTER_WIDTH-1:0] stat_ls_q;
    logic [COUNTER_WIDTH-1:0] stat_cf_q;

    always_ff @(posedge clk) begin
        if (s_reset) begin
            stat_if_q <= '0;
            stat_ls_q <= '0;
            stat_cf_q <= '0;
        end else begin
            if (if_gnt)           stat_if_q <= stat_if_q + COUNTER_WIDTH'(1);
            if (ls_gnt)           stat_ls_q <= stat_ls_q + COUNTER_WIDTH'(1);
            if (if_req && ls_req) stat_cf_q <= stat_cf_q + COUNTER_WIDTH'(1);
        end
    end

    assign stat_if_grants = stat_if_q;
    assign stat_ls_grants = stat_ls_q;
    assign stat_conflicts = stat_cf_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural 256-word RAM model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        s_reset;
    logic        if_req;
    logic [30:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [30:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [30:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;
    owner_t      dbg_owner;
`ifdef MEM_ARB_STATS_EN
    logic [11:0] stat_if_grants;
    logic [11:0] stat_ls_grants;
    logic [11:0] stat_conflicts;
`endif

    int vectors;
    int miscompares;

    mem_arbiter dut (
        .clk       (clk),
        .s_reset   (s_reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_be     (ls_be),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_be    (ram_be),
        .ram_rdata (ram_rdata),
        .dbg_owner (dbg_owner)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants (stat_if_grants),
        .stat_ls_grants (stat_ls_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr[7:0]];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_req   = 1'b0;
        if_addr  = '0;
        ls_req   = 1'b0;
        ls_we    = 1'b0;
        ls_addr  = '0;
        ls_wdata = '0;
        ls_be    = '0;
    endtask

    task automatic drive_ls(input logic we, input logic [30:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        ls_req   = 1'b1;
        ls_we    = we;
        ls_addr  = addr;
        ls_wdata = wdata;
        ls_be    = be;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        s_reset = 1'b1;
        drive_idle();
        if_req  = 1'b1;
        if_addr = 31'h7;
        drive_ls(1'b0, 31'h5, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({if_gnt, ls_gnt, ram_en, ram_we, if_rvalid, ls_rvalid} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl c%0d: got %b exp 000000", i,
                         {if_gnt, ls_gnt, ram_en, ram_we, if_rvalid, ls_rvalid});
            end
            vectors++;
            if ({ram_addr, ram_wdata, ram_be} !== 67'b0) begin
                miscompares++;
                $display("FAIL reset_ram c%0d: got addr %h wdata %h be %h exp 0", i,
                         ram_addr, ram_wdata, ram_be);
            end
            tick();
        end
        s_reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({if_gnt, ls_gnt, ram_en, ram_addr} !== {1'b0, 1'b1, 1'b1, 31'h5}) begin
            miscompares++;
            $display("FAIL reset_first_grant: got if_gnt %b ls_gnt %b en %b addr %h exp 0 1 1 5",
                     if_gnt, ls_gnt, ram_en, ram_addr);
        end
        tick();
        drive_idle();
        @(negedge clk);
        vectors++;
        if ({ls_rvalid, if_rvalid, ram_en} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_first_return: got ls_rv %b if_rv %b en %b exp 1 0 0",
                     ls_rvalid, if_rvalid, ram_en);
        end
        tick();
    endtask

    // Loads known words through the LS write path, back to back.
    task automatic test_ls_preload();
        logic [30:0] a_tab [3];
        logic [31:0] d_tab [3];
        a_tab = '{31'h10, 31'h11, 31'h20};
        d_tab = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h11111111};
        for (int i = 0; i < 3; i++) begin
            drive_ls(1'b1, a_tab[i], d_tab[i], 4'hF);
            @(negedge clk);
            vectors++;
            if ({ls_gnt, if_gnt, ram_en, ram_we, ram_addr, ram_wdata, ram_be, ls_rvalid} !==
                {1'b1, 1'b0, 1'b1, 1'b1, a_tab[i], d_tab[i], 4'hF, 1'b0}) begin
                miscompares++;
                $display("FAIL preload_wr%0d: got gnt %b en %b we %b addr %h wd %h be %h rv %b exp 1 1 1 %h %h f 0",
                         i, ls_gnt, ram_en, ram_we, ram_addr, ram_wdata, ram_be, ls_rvalid,
                         a_tab[i], d_tab[i]);
            end
            tick();
        end
        drive_idle();
        @(negedge clk);
        vectors++;
        if ({ls_rvalid, if_rvalid, ls_rdata, if_rdata} !== 66'b0) begin
            miscompares++;
            $display("FAIL preload_no_rvalid: got ls_rv %b if_rv %b exp 0 0", ls_rvalid, if_rvalid);
        end
        tick();
    endtask

    task automatic test_if_only();
        drive_idle();
        if_req  = 1'b1;
        if_addr = 31'h10;
        @(negedge clk);
        vectors++;
        if ({if_gnt, ls_gnt, ram_en, ram_we, ram_be, ram_addr} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 31'h10}) begin
            miscompares++;
            $display("FAIL if_grant: got gnt %b en %b we %b be %h addr %h exp 1 1 0 0 10",
                     if_gnt, ram_en, ram_we, ram_be, ram_addr);
        end
        tick();
        if_addr = 31'h11;
        @(negedge clk);
        vectors++;
        if ({if_gnt, if_rvalid, if_rdata, ls_rvalid, ls_rdata} !==
            {1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL if_stream1: got gnt %b rv %b rd %h ls_rv %b ls_rd %h exp 1 1 deadbeef 0 0",
                     if_gnt, if_rvalid, if_rdata, ls_rvalid, ls_rdata);
        end
        tick();
        drive_idle();
        @(negedge clk);
        vectors++;
        if ({if_gnt, ram_en, if_rvalid, if_rdata} !== {1'b0, 1'b0, 1'b1, 32'hCAFEF00D}) begin
            miscompares++;
            $display("FAIL if_stream2: got gnt %b en %b rv %b rd %h exp 0 0 1 cafef00d",
                     if_gnt, ram_en, if_rvalid, if_rdata);
        end
        tick();
        @(negedge clk);
        vectors++;
        if ({if_rvalid, if_rdata} !== 33'b0) begin
            miscompares++;
            $display("FAIL if_idle: got rv %b rd %h exp 0 0", if_rvalid, if_rdata);
        end
        tick();
    endtask

    task automatic test_ls_write_read();
        drive_ls(1'b1, 31'h20, 32'hA5A50000, 4'b1100);
        @(negedge clk);
        vectors++;
        if ({ls_gnt, ram_we, ram_be, ram_wdata} !== {1'b1, 1'b1, 4'b1100, 32'hA5A50000}) begin
            miscompares++;
            $display("FAIL lswr_grant: got gnt %b we %b be %b wd %h exp 1 1 1100 a5a50000",
                     ls_gnt, ram_we, ram_be, ram_wdata);
        end
        tick();
        drive_ls(1'b0, 31'h20, 32'h0, 4'hF);
        @(negedge clk);
        vectors++;
        if ({ls_gnt, ram_we, ls_rvalid} !== 3'b100) begin
            miscompares++;
            $display("FAIL lsrd_grant: got gnt %b we %b rv %b exp 1 0 0", ls_gnt, ram_we, ls_rvalid);
        end
        tick();
        drive_idle();
        @(negedge clk);
        vectors++;
        if ({ls_rvalid, ls_rdata, if_rvalid} !== {1'b1, 32'hA5A51111, 1'b0}) begin
            miscompares++;
            $display("FAIL lsrd_data: got rv %b rd %h if_rv %b exp 1 a5a51111 0",
                     ls_rvalid, ls_rdata, if_rvalid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_ls(1'b1, 31'h30, 32'h12345678, 4'hF);
        @(negedge clk);
        vectors++;
        if ({ls_gnt, if_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_write: got ls_gnt %b if_gnt %b exp 1 0", ls_gnt, if_gnt);
        end
        tick();
        drive_idle();
        if_req  = 1'b1;
        if_addr = 31'h30;
        @(negedge clk);
        vectors++;
        if ({if_gnt, ram_addr, ls_rvalid} !== {1'b1, 31'h30, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_read_grant: got gnt %b addr %h ls_rv %b exp 1 30 0",
                     if_gnt, ram_addr, ls_rvalid);
        end
        tick();
        drive_idle();
        @(negedge clk);
        vectors++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h12345678}) begin
            miscompares++;
            $display("FAIL b2b_read_data: got rv %b rd %h exp 1 12345678", if_rvalid, if_rdata);
        end
        tick();
    endtask

    // Both ports held: expect 8 LS grants then 1 IF grant, repeating.
    task automatic test_starvation();
        logic exp_if;
        logic prev_if;
        drive_idle();
        drive_ls(1'b0, 31'h10, 32'h0, 4'hF);
        if_req  = 1'b1;
        if_addr = 31'h11;
        for (int k = 0; k < 27; k++) begin
            exp_if  = ((k % 9) == 8);
            prev_if = (((k + 8) % 9) == 8);
            @(negedge clk);
            vectors++;
            if ({if_gnt, ls_gnt} !== {exp_if, !exp_if}) begin
                miscompares++;
                $display("FAIL starve_gnt k%0d: got if %b ls %b exp if %b ls %b",
                         k, if_gnt, ls_gnt, exp_if, !exp_if);
            end
            if (k > 0) begin
                vectors++;
                if ({if_rvalid, ls_rvalid, if_rdata, ls_rdata} !==
                    {prev_if, !prev_if, prev_if ? 32'hCAFEF00D : 32'h0,
                     prev_if ? 32'h0 : 32'hDEADBEEF}) begin
                    miscompares++;
                    $display("FAIL starve_ret k%0d: got if_rv %b ls_rv %b if_rd %h ls_rd %h exp if_rv %b",
                             k, if_rvalid, ls_rvalid, if_rdata, ls_rdata, prev_if);
                end
            end
            tick();
        end
        drive_idle();
        tick();
    endtask

    // IF drops its request before being served: nothing issued, age restarts.
    task automatic test_withdraw();
        drive_idle();
        drive_ls(1'b0, 31'h10, 32'h0, 4'hF);
        if_req  = 1'b1;
        if_addr = 31'h11;
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        if_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({if_gnt, ls_gnt, ram_addr} !== {1'b0, 1'b1, 31'h10}) begin
            miscompares++;
            $display("FAIL withdraw_cycle: got if %b ls %b addr %h exp 0 1 10", if_gnt, ls_gnt, ram_addr);
        end
        tick();
        if_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            vectors++;
            if ({if_gnt, ls_gnt} !== {(k == 8), (k != 8)}) begin
                miscompares++;
                $display("FAIL withdraw_age k%0d: got if %b ls %b exp if %b", k, if_gnt, ls_gnt, (k == 8));
            end
            tick();
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid_read();
        drive_ls(1'b0, 31'h10, 32'h0, 4'hF);
        @(negedge clk);
        vectors++;
        if (ls_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL midrd_grant: got %b exp 1", ls_gnt);
        end
        tick();
        drive_idle();
        s_reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ls_rvalid, ls_rdata, if_rvalid} !== 34'b0) begin
            miscompares++;
            $display("FAIL midrd_in_reset: got rv %b rd %h exp 0 0", ls_rvalid, ls_rdata);
        end
        tick();
        s_reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({ls_rvalid, if_rvalid, ram_en} !== 3'b0) begin
            miscompares++;
            $display("FAIL midrd_after: got ls_rv %b if_rv %b en %b exp 0 0 0", ls_rvalid, if_rvalid, ram_en);
        end
        tick();
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        drive_idle();
        s_reset = 1'b1;
        tick();
        s_reset = 1'b0;
        drive_ls(1'b0, 31'h10, 32'h0, 4'hF);
        if_req  = 1'b1;
        if_addr = 31'h11;
        @(negedge clk);
        vectors++;
        if ({stat_if_grants, stat_ls_grants, stat_conflicts} !== 36'b0) begin
            miscompares++;
            $display("FAIL stats_reset: got if %0d ls %0d cf %0d exp 0 0 0",
                     stat_if_grants, stat_ls_grants, stat_conflicts);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
        end
        drive_idle();
        @(negedge clk);
        vectors++;
        if ({stat_if_grants, stat_ls_grants, stat_conflicts} !== {12'd1, 12'd9, 12'd10}) begin
            miscompares++;
            $display("FAIL stats_count: got if %0d ls %0d cf %0d exp 1 9 10",
                     stat_if_grants, stat_ls_grants, stat_conflicts);
        end
        tick();
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        s_reset     = 1'b1;
        drive_idle();
        test_reset();
        test_ls_preload();
        test_if_only();
        test_ls_write_read();
        test_back_to_back();
        test_starvation();
        test_withdraw();
        test_reset_mid_read();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the CPU's single-port unified instruction/data RAM between two requesters: instruction fetch (IF) and load/store unit (LS).
- One access is granted per cycle; the RAM read latency is 1 cycle.
- Read data returns to the port that issued the read.
- Policy: LS has fixed priority, with aging on IF so that a stream of loads/stores cannot starve fetch.

Parameters:
- ADDR_WIDTH, 31, RAM word-address width.
- DATA_WIDTH, 32, data bus width (multiple of 8).
- STARVE_LIMIT, 8, IF wait cycles after which IF overrides LS priority (must be ≥1).
- COUNTER_WIDTH, 12, width of wait/statistics counters (must hold STARVE_LIMIT).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- s_reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF request; held with payload until if_gnt.
- if_addr  in  ADDR_WIDTH  IF word address (reads only).
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  DATA_WIDTH  IF read data.
- ls_req  in  1  LS request; held until ls_gnt.
- ls_we  in  1  1 = write, 0 = read.
- ls_addr  in  ADDR_WIDTH  LS word address.
- ls_wdata  in  DATA_WIDTH  write data.
- ls_be  in  DATA_WIDTH/8  byte enables for writes.
- ls_gnt  out  1  LS request accepted this cycle.
- ls_rvalid  out  1  LS read data valid.
- ls_rdata  out  DATA_WIDTH  LS read data.
- ram_en  out  1  RAM access this cycle.
- ram_we  out  1  RAM write.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_be  out  DATA_WIDTH/8  RAM byte enables.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after an enabled read.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset s_reset is synchronous and active-high.
  - During and after reset: all gnt/rvalid/ram_en/ram_we are 0; ram_addr/wdata/be are 0; wait counter is 0; owner state is IDLE.
- Grant (combinational from registered state and current requests):
  - If ls_req && !(if_req && if_wait ≥ STARVE_LIMIT): grant LS.
  - Else if if_req: grant IF.
  - Otherwise no grant.
  - At most one gnt per cycle.
- RAM drive:
  - In the grant cycle, ram_en=1 and the RAM signals mux the granted payload; the RAM samples at the next edge.
  - IF grants force ram_we=0 and ram_be=0.
  - With no grant, ram_en=0 and ram_we=0.
- Owner FSM (registered, tracks the read in flight):
  - States: IDLE, RD_IF, RD_LS.
  - Next state is RD_IF on an IF grant, RD_LS on an LS read grant, otherwise IDLE (LS writes return to IDLE).
  - Every state accepts a new grant in the same cycle, giving full throughput of one access per cycle.
- Read return:
  - In RD_IF: if_rvalid=1 and if_rdata=ram_rdata.
  - In RD_LS: ls_rvalid=1 and ls_rdata=ram_rdata.
  - Inactive rdata outputs are held at 0.
  - Writes never produce rvalid.
- IF wait counter:
  - Increments, saturating at all-ones, each cycle that if_req && !if_gnt.
  - Clears to 0 on if_gnt, and when if_req=0.
- Boundaries:
  - Simultaneous requests at the limit: IF wins and ls_gnt=0 that cycle; LS wins the next cycle (IF counter reset).
  - Back-to-back LS write then IF read to the same address: ordering is by grant, so the read sees the new data (RAM write-first not required, because the read is granted a cycle later).
  - Reset while a read is in flight: the pending rvalid is dropped and never asserted.
  - Requests deasserted before grant: nothing issued.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, three extra outputs are added, each COUNTER_WIDTH wide, wrapping, and reset to 0:
  - stat_if_grants: increments on if_gnt.
  - stat_ls_grants: increments on ls_gnt.
  - stat_conflicts: increments each cycle with if_req && ls_req.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] owner_t {IDLE, RD_IF, RD_LS};
  - a requester-id enum;
  - the default constants for the address and data widths.
- Sub-module arb_age_counter: a saturating wait counter with inc/clr/limit-reached flag; a separate instance is used if aging is later extended to LS.

Test Plan:
- Reset: hold s_reset high for 3 cycles with both req=1 -> no gnt, ram_en=0, no rvalid; first grant occurs in the first cycle after release (LS).
- IF only: if_addr=0x10, RAM word[0x10]=0xDEADBEEF -> if_gnt cycle N, if_rvalid and if_rdata=0xDEADBEEF at N+1; continuous requests produce one grant per cycle.
- LS write then read: write 0xA5A5_0000 be=4'b1100 to 0x20 (old word 0x1111_1111), then read 0x20 -> ls_rdata=0xA5A5_1111, no rvalid for the write.
- Starvation: if_req and ls_req held continuously, STARVE_LIMIT=8 -> 8 LS grants, then 1 IF grant, repeating the 8:1 pattern.
- Reset mid-read: assert s_reset in the cycle after ls_gnt (read) -> ls_rvalid stays 0.
- Stats (MEM_ARB_STATS_EN): 10 cycles with both requesting -> stat_conflicts=10 and stat_if_grants+stat_ls_grants=10.
